// File: rtl/shift_sequencer.sv
// shift_sequencer
// Sequences operand fetch for the execute-stage operand-2 barrel shifter.
// It accepts a data-processing instruction plus the issue-time C flag, and
// reads Rm and then Rs over one shared register-file port when the operand
// form needs them. The shifter inputs come only from registers. Operand2 and
// the carry-out are held in a result register behind a valid/ready handshake.
//
// Optional feature macro: SHSEQ_PC_OPERAND_EN
//   When defined, an Rm/Rs index of 15 takes pc_in+8 (or pc_in+12 for
//   register-specified shifts) instead of reading the register file.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   flush             synchronous abort of any in-flight operation
//   req_*             request handshake, instruction word and C flag at issue
//   rf_rd_*           shared register-file read port (data is combinational)
//   pc_in             current PC (only with SHSEQ_PC_OPERAND_EN)
//   sh_*              barrel-shifter inputs (registered) and results (comb)
//   res_*             result handshake with captured operand2 and carry
//
// state   | meaning
// IDLE    | waiting for a request
// READ_RM | register-file read of Rm into rm_q
// READ_RS | register-file read of Rs into rs_q
// SHIFT   | shifter inputs stable, capture operand2 and carry-out
// DONE    | result held until the consumer takes it

module shift_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_instr,
  input  logic         req_cin,
  output logic         rf_rd_en,
  output logic [3:0]   rf_rd_addr,
  input  logic [N-1:0] rf_rd_data,
`ifdef SHSEQ_PC_OPERAND_EN
  input  logic [N-1:0] pc_in,
`endif
  output logic         sh_instr_bit_25,
  output logic [11:0]  sh_imm_value,
  output logic [N-1:0] sh_rm,
  output logic [N-1:0] sh_rs,
  output logic         sh_cin,
  input  logic [N-1:0] sh_operand2,
  input  logic         sh_c_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_operand2,
  output logic         res_carry
);

  typedef enum logic [2:0] {
    IDLE,
    READ_RM,
    READ_RS,
    SHIFT,
    DONE
  } state_t;

  state_t       state;

  // Only the instruction bits the shifter and the sequencing use are kept.
  logic         instr_b25_q;
  logic [11:0]  instr_lo_q;
  logic         cin_q;
  logic [N-1:0] rm_q;
  logic [N-1:0] rs_q;

  logic         rm_from_pc;
  logic         rs_from_pc;
  logic [N-1:0] pc_value;

  logic         unused_instr_bits;
  assign unused_instr_bits = ^{req_instr[31:26], req_instr[24:12]};

`ifdef SHSEQ_PC_OPERAND_EN
  assign rm_from_pc = (instr_lo_q[3:0] == 4'hF);
  assign rs_from_pc = (instr_lo_q[11:8] == 4'hF);
  // PC reads as +12 when the shift amount itself comes from a register.
  assign pc_value   = pc_in + (instr_lo_q[4] ? N'(12) : N'(8));
`else
  assign rm_from_pc = 1'b0;
  assign rs_from_pc = 1'b0;
  assign pc_value   = '0;
`endif

  // Request side and read strobe must react to flush (and reset) in the same
  // cycle, so they are decoded from state rather than registered.
  assign req_ready = (state == IDLE) && !flush && !reset;

  always_comb begin
    rf_rd_en   = 1'b0;
    rf_rd_addr = 4'd0;
    if (!flush && !reset) begin
      if (state == READ_RM && !rm_from_pc) begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = instr_lo_q[3:0];
      end else if (state == READ_RS && !rs_from_pc) begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = instr_lo_q[11:8];
      end
    end
  end

  assign sh_instr_bit_25 = instr_b25_q;
  assign sh_imm_value    = instr_lo_q;
  assign sh_rm           = rm_q;
  assign sh_rs           = rs_q;
  assign sh_cin          = cin_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      instr_b25_q  <= 1'b0;
      instr_lo_q   <= '0;
      cin_q        <= 1'b0;
      rm_q         <= '0;
      rs_q         <= '0;
      res_valid    <= 1'b0;
      res_operand2 <= '0;
      res_carry    <= 1'b0;
    end else if (flush) begin
      // Captured data is left as-is; only control is abandoned.
      state     <= IDLE;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            instr_b25_q <= req_instr[25];
            instr_lo_q  <= req_instr[11:0];
            cin_q       <= req_cin;
            state       <= req_instr[25] ? SHIFT : READ_RM;
          end
        end
        READ_RM: begin
          rm_q  <= rm_from_pc ? pc_value : rf_rd_data;
          state <= instr_lo_q[4] ? READ_RS : SHIFT;
        end
        READ_RS: begin
          rs_q  <= rs_from_pc ? pc_value : rf_rd_data;
          state <= SHIFT;
        end
        SHIFT: begin
          res_operand2 <= sh_operand2;
          res_carry    <= sh_c_out;
          res_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer. Provides a register-file model,
// an ARM-style operand-2 shifter on the sh_* port, directed scenarios and a
// randomized run checked against the architectural operand-2 result.

module tb_shift_sequencer;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_instr;
  logic         req_cin;
  logic         rf_rd_en;
  logic [3:0]   rf_rd_addr;
  logic [N-1:0] rf_rd_data;
  logic [N-1:0] pc_in;
  logic         sh_instr_bit_25;
  logic [11:0]  sh_imm_value;
  logic [N-1:0] sh_rm;
  logic [N-1:0] sh_rs;
  logic         sh_cin;
  logic [N-1:0] sh_operand2;
  logic         sh_c_out;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_operand2;
  logic         res_carry;

  logic [31:0]  regs [16];
  logic [3:0]   rd_log [$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [31:0]  got_op2;
  logic         got_c;

  always #5 clk = ~clk;

  shift_sequencer #(.N(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_instr      (req_instr),
    .req_cin        (req_cin),
    .rf_rd_en       (rf_rd_en),
    .rf_rd_addr     (rf_rd_addr),
    .rf_rd_data     (rf_rd_data),
`ifdef SHSEQ_PC_OPERAND_EN
    .pc_in          (pc_in),
`endif
    .sh_instr_bit_25(sh_instr_bit_25),
    .sh_imm_value   (sh_imm_value),
    .sh_rm          (sh_rm),
    .sh_rs          (sh_rs),
    .sh_cin         (sh_cin),
    .sh_operand2    (sh_operand2),
    .sh_c_out       (sh_c_out),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_operand2   (res_operand2),
    .res_carry      (res_carry)
  );

  // Architectural operand-2 evaluation: returns {carry, value}.
  function automatic logic [32:0] operand2(input logic b25, input logic [11:0] f,
                                           input logic [31:0] rm, input logic [31:0] rs,
                                           input logic cin);
    logic [63:0] w;
    logic [31:0] r;
    logic        c;
    int          amt;
    int          a;
    if (b25) begin
      amt = 2 * int'(f[11:8]);
      w = {24'd0, f[7:0], 24'd0, f[7:0]} >> amt;
      r = w[31:0];
      c = (amt == 0) ? cin : r[31];
      return {c, r};
    end
    if (f[4]) amt = int'(rs[7:0]);
    else begin
      amt = int'(f[11:7]);
      if (amt == 0) begin
        if (f[6:5] == 2'd3) return {rm[0], cin, rm[31:1]};
        if (f[6:5] != 2'd0) amt = 32;
      end
    end
    r = rm;
    c = cin;
    if (amt != 0) begin
      case (f[6:5])
        2'd0: begin
          if (amt < 32)       begin r = rm << amt; c = rm[32-amt]; end
          else if (amt == 32) begin r = '0; c = rm[0]; end
          else                begin r = '0; c = 1'b0; end
        end
        2'd1: begin
          if (amt < 32)       begin r = rm >> amt; c = rm[amt-1]; end
          else if (amt == 32) begin r = '0; c = rm[31]; end
          else                begin r = '0; c = 1'b0; end
        end
        2'd2: begin
          if (amt < 32) begin r = $signed(rm) >>> amt; c = rm[amt-1]; end
          else          begin r = {32{rm[31]}}; c = rm[31]; end
        end
        default: begin
          a = amt % 32;
          if (a == 0) begin r = rm; c = rm[31]; end
          else begin
            w = {rm, rm} >> a;
            r = w[31:0];
            c = rm[a-1];
          end
        end
      endcase
    end
    return {c, r};
  endfunction

  assign rf_rd_data = regs[rf_rd_addr];
  assign {sh_c_out, sh_operand2} = operand2(sh_instr_bit_25, sh_imm_value, sh_rm, sh_rs, sh_cin);

  always @(posedge clk) if (rf_rd_en === 1'b1) rd_log.push_back(rf_rd_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] src_value(input logic [3:0] idx, input logic reg_shift);
`ifdef SHSEQ_PC_OPERAND_EN
    if (idx == 4'hF) return pc_in + (reg_shift ? 32'd12 : 32'd8);
`endif
    return regs[idx];
  endfunction

  function automatic bit uses_rf(input logic [3:0] idx);
`ifdef SHSEQ_PC_OPERAND_EN
    return idx != 4'hF;
`else
    return 1'b1;
`endif
  endfunction

  // One full transaction from an idle cycle: issue, latency, reads, result,
  // `hold` cycles of backpressure, then the handshake.
  task automatic do_op(input logic [31:0] instr, input logic cin, input int hold);
    logic [32:0] exp;
    logic [3:0]  exp_rd [$];
    int          exp_lat;
    int          lat;
    int          w;
    exp = operand2(instr[25], instr[11:0], src_value(instr[3:0], instr[4]),
                   src_value(instr[11:8], 1'b1), cin);
    exp_lat = instr[25] ? 1 : (instr[4] ? 3 : 2);
    exp_rd.delete();
    if (!instr[25]) begin
      if (uses_rf(instr[3:0])) exp_rd.push_back(instr[3:0]);
      if (instr[4] && uses_rf(instr[11:8])) exp_rd.push_back(instr[11:8]);
    end
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin tick(); w++; end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    rd_log.delete();
    req_instr = instr;
    req_cin   = cin;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_instr = $urandom;
    req_cin   = 1'($urandom);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 8) begin tick(); lat++; end
    check("latency", 32'(lat), 32'(exp_lat));
    check("operand2", res_operand2, exp[31:0]);
    check("carry", 32'(res_carry), 32'(exp[32]));
    check("rd_count", 32'(rd_log.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check("rd_addr", 32'(rd_log[i]), 32'(exp_rd[i]));
    got_op2 = res_operand2;
    got_c   = res_carry;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_op2", res_operand2, exp[31:0]);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("valid_drop", 32'(res_valid), 32'd0);
    check("ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_instr = '0;
    req_cin   = 1'b0;
    res_ready = 1'b0;
    pc_in     = '0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    #2;
    check("rst_outs", {req_ready, rf_rd_en, rf_rd_addr, res_valid, res_carry, sh_cin,
                       sh_instr_bit_25, sh_imm_value}, 32'd0);
    check("rst_rm", sh_rm, 32'd0);
    check("rst_op2", res_operand2, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Immediate form
    do_op(32'h020004FF, 1'b0, 0);
    check("t1_op2", got_op2, 32'hFF000000);
    check("t1_c", 32'(got_c), 32'd1);

    // Shift by immediate, LSL #1
    regs[3] = 32'h80000001;
    do_op(32'h00000083, 1'b0, 0);
    check("t2_op2", got_op2, 32'h00000002);
    check("t2_c", 32'(got_c), 32'd1);

    // Shift by register, LSR, with 5 cycles of backpressure
    regs[1] = 32'h000000F8;
    regs[2] = 32'h00000004;
    do_op(32'h00000231, 1'b0, 5);
    check("t3_op2", got_op2, 32'h0000000F);
    check("t3_c", 32'(got_c), 32'd1);

    // Flush while in READ_RS
    req_instr = 32'h00000231;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check("flush_rd_en", 32'(rf_rd_en), 32'd0);
    check("flush_ready", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_idle", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("flush_no_res", 32'(res_valid), 32'd0);
      tick();
    end
    do_op(32'h02000A3C, 1'b1, 1);

    // Reset while in SHIFT
    regs[5] = $urandom;
    req_instr = 32'h00000085;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_outs", {req_ready, rf_rd_en, rf_rd_addr, res_valid, res_carry, sh_cin,
                           sh_instr_bit_25, sh_imm_value}, 32'd0);
    check("mid_rst_rm", sh_rm, 32'd0);
    check("mid_rst_op2", res_operand2, 32'd0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_res", 32'(res_valid), 32'd0);
    end
    check("mid_rst_idle", 32'(req_ready), 32'd1);

`ifdef SHSEQ_PC_OPERAND_EN
    pc_in = 32'h100;
    do_op(32'h00000F1F, 1'b0, 0);
    check("pc_rm", sh_rm, 32'h10C);
    check("pc_rs", sh_rs, 32'h10C);
`endif

    // Randomized transactions
    for (int n = 0; n < 200; n++) begin
      logic [31:0] instr;
      instr = $urandom;
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      pc_in = $urandom;
      if (!instr[25] && instr[4] && ($urandom % 2 == 1))
        regs[instr[11:8]] = $urandom_range(0, 40);
      do_op(instr, 1'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle sequencer that feeds the operand-2 barrel shifter in the execute stage. It accepts a data-processing instruction and the issue-time C flag, and fetches Rm and Rs over one shared register-file read port when the operand form needs them. It drives the shifter inputs from stable registers, then captures operand2 and shifter carry-out into a result register with a valid/ready handshake. It is the only block that owns the shifter's input side.

Parameters:
N, 32, datapath width (register, operand2 and shifter width)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous abort of any in-flight operation
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_instr  input  32  instruction word; [25] immediate form, [11:0] shifter field, [11:8] Rs index, [3:0] Rm index
req_cin  input  1  CPSR C at issue
rf_rd_en  output  1  register-file read strobe
rf_rd_addr  output  4  register-file read index
rf_rd_data  input  N  combinational read data, valid in the same cycle as rf_rd_addr
sh_instr_bit_25  output  1  to shifter
sh_imm_value  output  12  to shifter
sh_rm  output  N  to shifter
sh_rs  output  N  to shifter
sh_cin  output  1  to shifter
sh_operand2  input  N  shifter result, combinational
sh_c_out  input  1  shifter carry-out, combinational
res_valid  output  1  result held
res_ready  input  1  consumer takes the result
res_operand2  output  N  captured operand2
res_carry  output  1  captured carry

Behaviour:
- States: IDLE, READ_RM, READ_RS, SHIFT, DONE. Reset state is IDLE.
- Reset values: all outputs 0; instr_q, cin_q, rm_q and rs_q are 0.
- req_ready = (state==IDLE) & ~flush.
- Accept on req_valid & req_ready. On accept, latch instr_q and cin_q.
- Next state on accept:
  - SHIFT if req_instr[25]=1.
  - Otherwise READ_RM.
- READ_RM: rf_rd_en=1, rf_rd_addr=instr_q[3:0]; rm_q captures rf_rd_data. Next state is READ_RS if instr_q[4]=1 (register-specified shift), otherwise SHIFT.
- READ_RS: rf_rd_en=1, rf_rd_addr=instr_q[11:8]; rs_q captures rf_rd_data. Next state is SHIFT.
- rf_rd_en=0 and rf_rd_addr=0 in every state other than READ_RM and READ_RS.
- Shifter inputs are driven only from registers and never from req_*:
  - sh_instr_bit_25=instr_q[25], sh_imm_value=instr_q[11:0].
  - sh_rm=rm_q, sh_rs=rs_q, sh_cin=cin_q.
- SHIFT: res_operand2 captures sh_operand2 and res_carry captures sh_c_out. Next state is DONE.
- DONE: res_valid=1 and the result is held stable. On res_ready, go to IDLE; res_valid=0 the following cycle.
- Latency from the accept edge to res_valid high:
  - 1 cycle for the immediate form.
  - 2 cycles for shift by immediate.
  - 3 cycles for shift by register.
- No overlap between requests: the next accept is possible at the earliest 1 cycle after the handshake.
- For immediate forms, rm_q and rs_q keep stale values; the shifter ignores them.
- flush in any state: next state IDLE, res_valid=0, no register-file read that cycle. Captured data registers are not cleared. flush overrides both req and res handshakes in the same cycle.
- reset asserted mid-operation: immediate return to IDLE with the reset values; no result is produced.

Optional Feature:
SHSEQ_PC_OPERAND_EN
- Defined:
  - Adds input pc_in [N-1:0].
  - An Rm or Rs index of 15 does not use the register file: rf_rd_en=0 in that state.
  - rm_q/rs_q load pc_in+8 for immediate-shift and immediate forms, and pc_in+12 when instr_q[4]=1.
  - State sequence and latency are unchanged.
- Undefined: no pc_in port; index 15 is read through the register file like any other register.

Test Plan:
1. Immediate form: req_instr=0x020004FF, cin=0 → res_valid 1 cycle after accept, operand2=0xFF000000, carry=1, rf_rd_en never asserted.
2. Shift by immediate (LSL #1): instr=0x00000083, r3=0x80000001, cin=0 → one read of addr 3, result 0x00000002, carry=1, latency 2.
3. Shift by register (LSR): instr=0x00000231, r1=0x000000F8, r2=0x00000004 → reads addr 1 then addr 2, result 0x0000000F, carry=1, latency 3.
4. Backpressure: hold res_ready=0 for 5 cycles in DONE → result stable, req_ready=0 throughout; res_ready=1 → req_ready=1 the next cycle.
5. flush asserted in READ_RS → IDLE next cycle, res_valid never rises; a new immediate request then completes with the correct result.
6. reset pulsed in SHIFT → all outputs 0, IDLE; with SHSEQ_PC_OPERAND_EN, instr=0x00000F1F with pc_in=0x100 (Rm=Rs=15) gives rm_q=rs_q=0x10C and no register-file reads.
